// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring divider for the EX stage (div / divu).
//
// One quotient bit is produced per clock. Signed operands are converted to
// magnitudes on acceptance and the signs are re-applied when the final step
// completes. A zero divisor bypasses the iteration and yields 64'h0.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   start_i     division request held by EX
//   signed_i    1 = div (two's complement), 0 = divu; sampled on acceptance
//   opdata1_i   dividend; sampled on acceptance
//   opdata2_i   divisor; sampled on acceptance
//   annul_i     abort the current operation (pipeline flush)
//   result_o    {remainder, quotient}, held until the next acceptance
//   ready_o     result_o is valid
//   stallreq_o  stall request while a division is in flight (combinational)
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W:0]     partial;
    logic [DATA_W-1:0]     divisor;
    logic                  neg_quot;
    logic                  neg_rem;

    logic                  op1_neg;
    logic                  op2_neg;
    logic [DATA_W-1:0]     abs1;
    logic [DATA_W-1:0]     abs2;
    logic [2*DATA_W:0]     shifted;
    logic [DATA_W+1:0]     diff;
    logic [2*DATA_W:0]     step_next;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    // Magnitudes of the incoming operands (only meaningful at acceptance).
    always_comb begin
        op1_neg = signed_i & opdata1_i[DATA_W-1];
        op2_neg = signed_i & opdata2_i[DATA_W-1];
        abs1    = op1_neg ? -opdata1_i : opdata1_i;
        abs2    = op2_neg ? -opdata2_i : opdata2_i;
    end

    // One restoring step: shift, trial-subtract from the upper window, and
    // keep the difference only when it did not borrow.
    always_comb begin
        shifted = partial << 1;
        diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};
        if (!diff[DATA_W+1])
            step_next = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
        else
            step_next = {shifted[2*DATA_W:1], 1'b0};
        quo     = step_next[DATA_W-1:0];
        rem     = step_next[2*DATA_W-1:DATA_W];
        quo_fix = neg_quot ? -quo : quo;
        rem_fix = neg_rem  ? -rem : rem;
    end

    assign stallreq_o = rst & start_i & (state != S_END);

    // ready_o is registered from the END state, so it rises one edge after
    // END is entered (T+33 for a real divide, T+2 for a zero divisor).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            partial  <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_DIVZERO;
                        end else begin
                            state    <= S_ON;
                            cnt      <= '0;
                            partial  <= {{(DATA_W+1){1'b0}}, abs1};
                            divisor  <= abs2;
                            neg_quot <= op1_neg ^ op2_neg;
                            neg_rem  <= op1_neg;
                        end
                    end
                end
                S_DIVZERO: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        state    <= S_END;
                        result_o <= '0;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        partial <= step_next;
                        cnt     <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state    <= S_END;
                            result_o <= {rem_fix, quo_fix};
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b0;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed self-checking bench for div_unit.
//
// Each scenario task drives stimulus and checks results inline against
// hand-computed values. Inputs change on the falling edge or just after the
// rising edge; outputs are sampled on the falling edge.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks;
    int failures;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start at a falling edge, scramble operands right after the
    // accepting edge, then count edges until ready_o is seen (bounded).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat,
                          output logic stall_first, output logic stall_end);
        @(negedge clk);
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
        lat = 0;
        stall_first = 1'b0;
        while (lat < 60) begin
            @(negedge clk);
            if (lat == 0) stall_first = stallreq_o;
            if (ready_o) break;
            @(posedge clk);
            lat++;
        end
        res       = result_o;
        stall_end = stallreq_o;
    endtask

    // Drop start and return ready_o and result_o one edge later.
    task automatic release_op(output logic rdy, output logic [63:0] res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rdy = ready_o;
        res = result_o;
    endtask

    task automatic test_reset;
        rst = 1'b0; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = 32'd5; opdata2_i = 32'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (stallreq_o !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", stallreq_o);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0", ready_o);
        end
        checks++;
        if (result_o !== 64'h0) begin
            failures++; $display("FAIL reset_result got=%h exp=0", result_o);
        end
        start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic;
        logic [63:0] res; int lat; logic sf, se, rdy;
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            failures++; $display("FAIL stall_comb got=%b exp=1", stallreq_o);
        end
        start_i = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, res, lat, sf, se);
        checks++;
        if (lat !== 33) begin
            failures++; $display("FAIL divu_latency got=%0d exp=33", lat);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            failures++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'd2, 32'd14});
        end
        checks++;
        if (sf !== 1'b1) begin
            failures++; $display("FAIL stall_in_on got=%b exp=1", sf);
        end
        checks++;
        if (se !== 1'b0) begin
            failures++; $display("FAIL stall_in_end got=%b exp=0", se);
        end
        release_op(rdy, res);
        checks++;
        if (rdy !== 1'b0) begin
            failures++; $display("FAIL ready_clear got=%b exp=0", rdy);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            failures++; $display("FAIL result_hold got=%h exp=%h", res, {32'd2, 32'd14});
        end
    endtask

    task automatic test_signed;
        logic [63:0] vec_res [0:4];
        logic [31:0] va [0:4];
        logic [31:0] vb [0:4];
        logic        vs [0:4];
        logic [63:0] res; int lat; logic sf, se, rdy;
        va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        vs[0] = 1'b1; vec_res[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
        va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1; vec_res[1] = {32'h00000001, 32'hFFFFFFFD};
        va[2] = 32'hFFFFFF9C; vb[2] = 32'hFFFFFFF9; vs[2] = 1'b1; vec_res[2] = {32'hFFFFFFFE, 32'd14};
        va[3] = 32'd5;        vb[3] = 32'd9;        vs[3] = 1'b0; vec_res[3] = {32'd5, 32'd0};
        va[4] = 32'hFFFFFFF9; vb[4] = 32'h2;        vs[4] = 1'b0; vec_res[4] = {32'd1, 32'h7FFFFFFC};
        for (int i = 0; i < 5; i++) begin
            run_op(vs[i], va[i], vb[i], res, lat, sf, se);
            checks++;
            if (res !== vec_res[i] || lat !== 33) begin
                failures++;
                $display("FAIL signed_vec%0d got=%h lat=%0d exp=%h lat=33", i, res, lat, vec_res[i]);
            end
            release_op(rdy, res);
        end
    endtask

    task automatic test_divzero;
        logic [63:0] res; int lat; logic sf, se, rdy;
        run_op(1'b0, 32'h12345678, 32'd0, res, lat, sf, se);
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL divzero_latency got=%0d exp=2", lat);
        end
        checks++;
        if (res !== 64'h0) begin
            failures++; $display("FAIL divzero_result got=%h exp=0", res);
        end
        release_op(rdy, res);
    endtask

    task automatic test_boundary;
        logic [63:0] res; int lat; logic sf, se, rdy;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, res, lat, sf, se);
        checks++;
        if (res !== {32'h0, 32'h80000000}) begin
            failures++; $display("FAIL overflow got=%h exp=%h", res, {32'h0, 32'h80000000});
        end
        release_op(rdy, res);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, res, lat, sf, se);
        checks++;
        if (res !== {32'h0, 32'hFFFFFFFF}) begin
            failures++; $display("FAIL divu_max_1 got=%h exp=%h", res, {32'h0, 32'hFFFFFFFF});
        end
        release_op(rdy, res);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, sf, se);
        checks++;
        if (res !== {32'h0, 32'd1}) begin
            failures++; $display("FAIL divu_max_max got=%h exp=%h", res, {32'h0, 32'd1});
        end
        release_op(rdy, res);
    endtask

    task automatic test_annul;
        logic [63:0] res; int lat; logic sf, se, rdy; logic [63:0] held; int seen;
        held = {32'h0, 32'd1};
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL annul_ready got=%0d exp=0", seen);
        end
        checks++;
        if (result_o !== held) begin
            failures++; $display("FAIL annul_result got=%h exp=%h", result_o, held);
        end
        run_op(1'b0, 32'd9, 32'd4, res, lat, sf, se);
        checks++;
        if (res !== {32'd1, 32'd2} || lat !== 33) begin
            failures++; $display("FAIL after_annul got=%h lat=%0d exp=%h lat=33", res, lat, {32'd1, 32'd2});
        end
        release_op(rdy, res);

        // start and annul together in IDLE: not accepted until annul drops
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd6; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        lat = 0;
        @(posedge clk);
        while (lat < 60) begin
            @(negedge clk);
            if (ready_o) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33 || result_o !== {32'd2, 32'd8}) begin
            failures++; $display("FAIL annul_idle got=%h lat=%0d exp=%h lat=33", result_o, lat, {32'd2, 32'd8});
        end
        release_op(rdy, res);
    endtask

    task automatic test_reset_mid_op;
        logic [63:0] res; int lat; logic rdy;
        @(negedge clk);
        opdata1_i = 32'd77; opdata2_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (result_o !== 64'h0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h rdy=%b stall=%b exp=0 rdy=0 stall=0", result_o, ready_o, stallreq_o);
        end
        opdata1_i = 32'd20; opdata2_i = 32'd6;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom; opdata2_i = $urandom;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (ready_o) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33 || result_o !== {32'd2, 32'd3}) begin
            failures++; $display("FAIL reset_restart got=%h lat=%0d exp=%h lat=33", result_o, lat, {32'd2, 32'd3});
        end
        release_op(rdy, res);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_divu_basic;
        test_signed;
        test_divzero;
        test_boundary;
        test_annul;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
